// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: icache request/response, redirect, decode handshake and occupancy.
// master = fetch unit side, slave = environment (icache, branch unit, decode).
interface fetch_queue_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               ic_req_valid;
    logic [PC_W-1:0]    ic_req_addr;
    logic               ic_req_ready;
    logic               ic_rsp_valid;
    logic [INSTR_W-1:0] ic_rsp_instr;
    logic               redir_valid;
    logic [PC_W-1:0]    redir_pc;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;
    logic               dec_ready;
    logic [CNT_W-1:0]   fq_count;

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_instr,
        input  redir_valid, redir_pc,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready,
        output fq_count
    );

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_rsp_valid, ic_rsp_instr,
        output redir_valid, redir_pc,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready,
        input  fq_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch: PC owner, credit-limited icache requests, in-order fetch queue.
// Optional FQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned TAG_PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned INF_W     = $clog2(MAX_OUT + 1);

    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      fq_pc_q    [DEPTH];
    logic [INSTR_W-1:0]   fq_instr_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PC_W-1:0]      tag_q [MAX_OUT];
    logic [TAG_PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [INF_W-1:0]     inflight_q, inflight_d, drop_q, drop_d;

    logic req_valid_c, req_fire_c, rsp_acc_c, push_c, pop_c, bypass_c, redir_c;

    function automatic logic [TAG_PTR_W-1:0] tag_inc(input logic [TAG_PTR_W-1:0] p);
        return (p == TAG_PTR_W'(MAX_OUT - 1)) ? '0 : p + TAG_PTR_W'(1);
    endfunction

    // Handshake qualification; the credit rule reserves a queue slot for every outstanding request.
    always_comb begin
        redir_c     = bus.redir_valid;
        req_valid_c = !rst && !redir_c && (32'(inflight_q) < MAX_OUT)
                      && ((32'(count_q) + 32'(inflight_q)) < DEPTH);
        req_fire_c  = req_valid_c && bus.ic_req_ready;
        rsp_acc_c   = bus.ic_rsp_valid && (inflight_q != '0);
`ifdef FQ_BYPASS_EN
        bypass_c    = !rst && rsp_acc_c && (count_q == '0) && (drop_q == '0)
                      && !redir_c && bus.dec_ready;
`else
        bypass_c    = 1'b0;
`endif
        push_c      = rsp_acc_c && !redir_c && (drop_q == '0) && !bypass_c;
        pop_c       = (count_q != '0) && !redir_c && bus.dec_ready;
    end

    assign bus.ic_req_valid = req_valid_c;
    assign bus.ic_req_addr  = pc_q;
    assign bus.dec_valid    = !rst && (((count_q != '0) && !redir_c) || bypass_c);
    assign bus.dec_pc       = bypass_c ? tag_q[tag_rd_q] : fq_pc_q[rd_ptr_q];
    assign bus.dec_instr    = bypass_c ? bus.ic_rsp_instr : fq_instr_q[rd_ptr_q];
    assign bus.fq_count     = rst ? '0 : count_q;

    always_comb begin
        pc_d       = pc_q;
        tag_wr_d   = req_fire_c ? tag_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d   = rsp_acc_c ? tag_inc(tag_rd_q) : tag_rd_q;
        inflight_d = inflight_q + INF_W'(req_fire_c) - INF_W'(rsp_acc_c);
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (req_fire_c) begin
            pc_d = pc_q + PC_W'(4);
        end
        if (rsp_acc_c && (drop_q != '0)) begin
            drop_d = drop_q - INF_W'(1);
        end
        // Squash everything still in flight; pending drops are already part of inflight.
        if (redir_c) begin
            pc_d     = bus.redir_pc & ~PC_W'(3);
            drop_d   = inflight_q - INF_W'(rsp_acc_c);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_fire_c) begin
            tag_q[tag_wr_q] <= pc_q;
        end
        if (push_c) begin
            fq_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
            fq_instr_q[wr_ptr_q] <= bus.ic_rsp_instr;
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        bus.ic_rsp_valid |-> (inflight_q != '0));
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios then random traffic vs a queue model.
module tb_fetch_queue_unit;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    fetch_queue_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        outq[$];
    ent_t        fq[$];
    logic [31:0] m_pc = RST_PC;

    int n_cmp = 0;
    int n_mis = 0;

    logic        obs_dv, obs_rv;
    logic [31:0] obs_pc, obs_addr;
    logic [2:0]  obs_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int stale_cnt();
        int n = 0;
        foreach (outq[i]) if (outq[i].stale) n++;
        return n;
    endfunction

    // One clock: drive inputs after negedge, check outputs, advance model on posedge.
    task automatic step(input bit r, input bit rq_rdy, input bit rsp_want,
                        input bit rd, input logic [31:0] rd_pc, input bit dr);
        bit          rv, exp_rv, exp_dv, byp;
        logic [31:0] ins, e_pc, e_ins;
        req_t        o;
        rv  = rsp_want && !r && (outq.size() != 0);
        ins = $urandom;
        rst              = r;
        bus.ic_req_ready = rq_rdy;
        bus.ic_rsp_valid = rv;
        bus.ic_rsp_instr = ins;
        bus.redir_valid  = rd;
        bus.redir_pc     = rd_pc;
        bus.dec_ready    = dr;
        #1;
        exp_rv = !r && !rd && (outq.size() < MAX_OUT) && ((fq.size() + outq.size()) < DEPTH);
        byp = 1'b0;
`ifdef FQ_BYPASS_EN
        if (!r && rv && (fq.size() == 0) && !rd && dr && !outq[0].stale) byp = 1'b1;
`endif
        exp_dv = !r && (((fq.size() != 0) && !rd) || byp);
        chk("fq_count", 64'(bus.fq_count), r ? 64'd0 : 64'(fq.size()));
        chk("req_valid", 64'(bus.ic_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(bus.ic_req_addr), 64'(m_pc));
        chk("dec_valid", 64'(bus.dec_valid), 64'(exp_dv));
        if (exp_dv) begin
            e_pc  = byp ? outq[0].pc : fq[0].pc;
            e_ins = byp ? ins : fq[0].instr;
            chk("dec_pc", 64'(bus.dec_pc), 64'(e_pc));
            chk("dec_instr", 64'(bus.dec_instr), 64'(e_ins));
        end
        obs_dv   = bus.dec_valid;
        obs_rv   = bus.ic_req_valid;
        obs_pc   = bus.dec_pc;
        obs_addr = bus.ic_req_addr;
        obs_cnt  = bus.fq_count;
        @(posedge clk);
        if (r) begin
            outq.delete();
            fq.delete();
            m_pc = RST_PC;
        end else begin
            if (rv) o = outq.pop_front();
            if ((fq.size() != 0) && !rd && dr) void'(fq.pop_front());
            if (rv && !rd && !o.stale && !byp) fq.push_back(ent_t'{o.pc, ins});
            if (exp_rv && rq_rdy) begin
                outq.push_back(req_t'{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (rd) begin
                fq.delete();
                foreach (outq[i]) outq[i].stale = 1'b1;
                m_pc = rd_pc & ~32'h3;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] nxt;
        int          seen;
        bit          got_req, got_dec;
        bus.ic_req_ready = 1'b0;
        bus.ic_rsp_valid = 1'b0;
        bus.ic_rsp_instr = '0;
        bus.redir_valid  = 1'b0;
        bus.redir_pc     = '0;
        bus.dec_ready    = 1'b0;
        @(negedge clk);

        // Reset for three cycles, then the first request address is RESET_PC.
        repeat (3) step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_addr", 64'(obs_addr), 64'h100);
        chk("t1_dec_valid", 64'(obs_dv), 64'd0);
        chk("t1_count", 64'(obs_cnt), 64'd0);

        // Streaming with one-cycle responses: sequential PCs with no bubbles.
        nxt  = 32'h100;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 0, 0, 1);
            if (obs_dv) begin
                chk("t2_seq", 64'(obs_pc), 64'(nxt));
                nxt = nxt + 32'd4;
                seen++;
            end
        end
`ifdef FQ_BYPASS_EN
        chk("t2_beats", 64'(seen), 64'd11);
`else
        chk("t2_beats", 64'(seen), 64'd10);
`endif

        // Decode stalled: queue fills to DEPTH and requests stop.
        repeat (8) step(0, 1, 1, 0, 0, 0);
        chk("t3_full", 64'(obs_cnt), 64'd4);
        chk("t3_no_req", 64'(obs_rv), 64'd0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("t3_req_after_pop", 64'(obs_rv), 64'd1);

        // Two requests in flight, redirect to a misaligned target squashes both.
        step(0, 0, 1, 1, 32'h200, 1);
        while (outq.size() != 0) step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 32'h200, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("t4_req0", 64'(obs_addr), 64'h200);
        step(0, 1, 0, 0, 0, 1);
        chk("t4_req1", 64'(obs_addr), 64'h204);
        step(0, 0, 0, 1, 32'h302, 1);
        got_req = 1'b0;
        got_dec = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 0, 0, 1);
            if (obs_rv && !got_req) begin
                chk("t4_first_req", 64'(obs_addr), 64'h300);
                got_req = 1'b1;
            end
            if (obs_dv && !got_dec) begin
                chk("t4_first_dec", 64'(obs_pc), 64'h300);
                got_dec = 1'b1;
            end
        end
        chk("t4_progress", 64'({got_req, got_dec}), 64'd3);

        // Redirect coincident with a response and a decode pop.
        step(0, 0, 0, 1, 32'h400, 0);
        while (outq.size() != 0) step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h500, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t5_count", 64'(obs_cnt), 64'd0);
        chk("t5_drop", 64'(dut.drop_q), 64'(stale_cnt()));
        chk("t5_drop_val", 64'(stale_cnt()), 64'd1);
        repeat (10) step(0, 1, 1, 0, 0, 1);

        // Response-to-decode latency from an empty queue.
        repeat (2) step(1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
`ifdef FQ_BYPASS_EN
        chk("t6_same_cycle", 64'(obs_dv), 64'd1);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_next_cycle", 64'(obs_dv), 64'd0);
`else
        chk("t6_same_cycle", 64'(obs_dv), 64'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_next_cycle", 64'(obs_dv), 64'd1);
`endif

        // Random traffic with occasional redirects and resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 256) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
